// File: rtl/stream_arbiter_pkg.sv
// stream_arbiter_pkg
//   Shared definitions for the round-robin packet arbiter.
//   state_t : arbiter FSM encoding (ST_IDLE = 1'b0, ST_BUSY = 1'b1)
package stream_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_select.sv
// rr_select
//   Combinational round-robin search. Rotates the request vector so that the
//   input after `last` sits at position 0, picks the lowest set bit, and
//   rotates the result back to an absolute input index.
// Ports:
//   req  in  NUM_INPUTS : request vector
//   last in  SEL_WIDTH  : index granted most recently (lowest priority)
//   sel  out SEL_WIDTH  : chosen index (don't care when any = 0)
//   any  out 1          : at least one request present
module rr_select #(
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_WIDTH-1:0]  last,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic                  any
);

  logic [NUM_INPUTS-1:0] rot;
  int                    offset;

  always_comb begin
    rot    = '0;
    offset = 0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      rot[i] = req[SEL_WIDTH'((int'(last) + 1 + i) % NUM_INPUTS)];
    end
    // Scan downward so the lowest set position is the one that sticks.
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        offset = i;
      end
    end
    any = |req;
    sel = SEL_WIDTH'((int'(last) + 1 + offset) % NUM_INPUTS);
  end

endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter
//   Round-robin packet arbiter sharing one registered stream output between
//   NUM_INPUTS sources. A grant is held from the first beat until the beat
//   carrying in_last; one IDLE cycle of arbitration separates packets.
// Ports:
//   aclk, areset        : clock, synchronous active-high reset
//   in_data/valid/last  : packed per-input stream (input i at [i*DATA_WIDTH +: DATA_WIDTH])
//   in_ready            : per-input ready, at most one bit set
//   out_data/last/sel   : registered output beat and its source index
//   out_valid/out_ready : output handshake
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | no grant; pick next requester after last_grant
//   BUSY    | grant held until a transferred beat carries in_last
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS-1:0]            in_last,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [SEL_WIDTH-1:0]             out_sel,
  output logic                             out_valid,
  input  logic                             out_ready
);

  state_t                 state, state_nxt;
  logic [SEL_WIDTH-1:0]   grant, grant_nxt;
  logic [SEL_WIDTH-1:0]   last_grant, last_grant_nxt;
  logic [SEL_WIDTH-1:0]   rr_sel;
  logic                   rr_any;
  logic                   load;
  logic                   xfer;
  logic [DATA_WIDTH-1:0]  mux_data;
  logic                   mux_last;
  logic                   mux_valid;

  rr_select #(
    .NUM_INPUTS(NUM_INPUTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_select (
    .req (in_valid),
    .last(last_grant),
    .sel (rr_sel),
    .any (rr_any)
  );

  // Output register can take a beat when empty or draining this cycle.
  assign load = ~out_valid | out_ready;

  always_comb begin
    mux_data  = '0;
    mux_last  = 1'b0;
    mux_valid = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (SEL_WIDTH'(i) == grant) begin
        mux_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        mux_last  = in_last[i];
        mux_valid = in_valid[i];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    in_ready       = '0;
    xfer           = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rr_any) begin
          grant_nxt = rr_sel;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (SEL_WIDTH'(i) == grant) begin
            in_ready[i] = load;
          end
        end
        xfer = mux_valid & load;
        if (xfer & mux_last) begin
          state_nxt      = ST_IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= SEL_WIDTH'(NUM_INPUTS - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_last  <= mux_last;
      out_data  <= mux_data;
      out_sel   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter
//   Directed scenarios followed by a randomized run. Sources are modelled as
//   packet generators; every generated beat is recorded per source and the
//   output stream is scored against those records.
module tb_stream_arbiter;

  localparam int NI    = 4;
  localparam int DW    = 32;
  localparam int SW    = 2;
  localparam int DEPTH = 4096;
  localparam int LOGN  = 64;

  logic            aclk      = 1'b0;
  logic            areset    = 1'b1;
  logic [NI*DW-1:0] in_data  = '0;
  logic [NI-1:0]   in_valid  = '0;
  logic [NI-1:0]   in_last   = '0;
  logic [NI-1:0]   in_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [SW-1:0]   out_sel;
  logic            out_valid;
  logic            out_ready = 1'b1;

  stream_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_INPUTS(NI)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // source generator state
  bit          pres [NI];
  bit          en   [NI];
  bit          pause[NI];
  int          rem  [NI];
  int          cur_k[NI];
  int          plen [NI];
  int          npkt [NI];
  bit          rnd;
  bit          fixed_a5;

  // scoreboard
  logic [DW-1:0] exp_data[NI][DEPTH];
  bit            exp_last[NI][DEPTH];
  int            gen_cnt[NI];
  int            out_cnt[NI];
  logic [NI-1:0] hs;
  int            open_src;

  // output log for directed checks
  int            lg_n;
  int            lg_sel [LOGN];
  int            lg_cyc [LOGN];
  logic [DW-1:0] lg_data[LOGN];
  bit            lg_last[LOGN];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int s = 0; s < NI; s++) begin
      in_valid[s]          = pres[s] && !pause[s];
      in_data[s*DW +: DW]  = pres[s] ? exp_data[s][cur_k[s]] : '0;
      in_last[s]           = pres[s] && exp_last[s][cur_k[s]];
    end
  endtask

  task automatic advance_all();
    for (int s = 0; s < NI; s++) begin
      if (hs[s]) pres[s] = 1'b0;
      if (!pres[s]) begin
        bit want;
        if (rem[s] > 0) want = !rnd || ($urandom_range(3) != 0);
        else            want = en[s] && (npkt[s] != 0) && (!rnd || ($urandom_range(3) != 0));
        if (gen_cnt[s] >= DEPTH - 1) want = 1'b0;
        if (want) begin
          int k;
          if (rem[s] == 0) begin
            rem[s] = (plen[s] > 0) ? plen[s] : int'($urandom_range(4, 1));
            if (npkt[s] > 0) npkt[s]--;
          end
          k = gen_cnt[s];
          exp_data[s][k] = fixed_a5 ? 32'hA5A5_A5A5 : $urandom;
          exp_last[s][k] = (rem[s] == 1);
          rem[s]--;
          gen_cnt[s]++;
          cur_k[s] = k;
          pres[s]  = 1'b1;
        end
      end
    end
    drive();
  endtask

  task automatic refresh();
    hs = '0;
    advance_all();
  endtask

  task automatic monitor();
    hs = in_valid & in_ready;
    if (!areset) begin
      check("ready_onehot", 64'($onehot0(in_ready)), 64'd1);
      if (out_valid && !out_ready) check("ready_while_stalled", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        int s, k;
        s = int'(out_sel);
        k = out_cnt[s];
        check("beat_exists", 64'(k < gen_cnt[s]), 64'd1);
        if (k < gen_cnt[s]) begin
          check("beat_data", 64'(out_data), 64'(exp_data[s][k]));
          check("beat_last", 64'(out_last), 64'(exp_last[s][k]));
        end
        if (open_src >= 0) check("no_interleave", 64'(s), 64'(open_src));
        open_src = out_last ? -1 : s;
        out_cnt[s]++;
        if (lg_n < LOGN) begin
          lg_sel[lg_n]  = s;
          lg_cyc[lg_n]  = cyc;
          lg_data[lg_n] = out_data;
          lg_last[lg_n] = out_last;
        end
        lg_n++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
    cyc++;
    advance_all();
  endtask

  task automatic src_clear();
    for (int s = 0; s < NI; s++) begin
      pres[s]    = 1'b0;
      en[s]      = 1'b0;
      pause[s]   = 1'b0;
      rem[s]     = 0;
      cur_k[s]   = 0;
      plen[s]    = 1;
      npkt[s]    = 0;
      gen_cnt[s] = 0;
      out_cnt[s] = 0;
    end
    rnd      = 1'b0;
    fixed_a5 = 1'b0;
    open_src = -1;
    lg_n     = 0;
    hs       = '0;
    drive();
  endtask

  task automatic do_reset();
    areset    = 1'b1;
    out_ready = 1'b1;
    src_clear();
    repeat (2) cycle();
    areset = 1'b0;
  endtask

  function automatic bit drained();
    bit d;
    d = !out_valid;
    for (int s = 0; s < NI; s++) begin
      if (pres[s] || rem[s] != 0 || out_cnt[s] != gen_cnt[s]) d = 1'b0;
    end
    return d;
  endfunction

  initial begin
    int tot;

    // reset values
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_sel",   64'(out_sel),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);

    // all four inputs, 2-beat packets: round-robin order, one bubble per packet
    do_reset();
    for (int s = 0; s < NI; s++) begin
      en[s] = 1'b1; plen[s] = 2; npkt[s] = -1;
    end
    refresh();
    for (int t = 0; t < 100 && lg_n < 16; t++) cycle();
    check("rr_count", 64'(lg_n >= 16), 64'd1);
    for (int i = 0; i < 16; i++) begin
      check("rr_sel", 64'(lg_sel[i]), 64'((i / 2) % NI));
      if (i > 0) check("rr_gap", 64'(lg_cyc[i] - lg_cyc[i-1]), 64'((i % 2 == 0) ? 2 : 1));
    end

    // only input 2, single-beat packets of a fixed word
    do_reset();
    en[2] = 1'b1; plen[2] = 1; npkt[2] = -1; fixed_a5 = 1'b1;
    refresh();
    for (int t = 0; t < 100 && lg_n < 6; t++) cycle();
    check("single_count", 64'(lg_n >= 6), 64'd1);
    for (int i = 0; i < 6; i++) begin
      check("single_data", 64'(lg_data[i]), 64'h0000_0000_A5A5_A5A5);
      check("single_sel",  64'(lg_sel[i]),  64'd2);
      check("single_last", 64'(lg_last[i]), 64'd1);
      if (i > 0) check("single_gap", 64'(lg_cyc[i] - lg_cyc[i-1]), 64'd2);
    end

    // input 1, 4-beat packet, output back-pressured for 3 cycles mid-packet
    do_reset();
    en[1] = 1'b1; plen[1] = 4; npkt[1] = 1;
    refresh();
    for (int t = 0; t < 50 && lg_n < 1; t++) cycle();
    check("stall_start", 64'(lg_n), 64'd1);
    out_ready = 1'b0;
    repeat (3) begin
      #2;
      check("stall_valid",    64'(out_valid),   64'd1);
      check("stall_data",     64'(out_data),    64'(exp_data[1][out_cnt[1]]));
      check("stall_sel",      64'(out_sel),     64'd1);
      check("stall_in_ready", 64'(in_ready[1]), 64'd0);
      cycle();
    end
    out_ready = 1'b1;
    for (int t = 0; t < 50 && out_cnt[1] < 4; t++) cycle();
    repeat (4) cycle();
    check("stall_beats_out", 64'(out_cnt[1]), 64'd4);
    check("stall_beats_gen", 64'(gen_cnt[1]), 64'd4);

    // input 0 drops valid mid-packet while input 3 waits: no preemption
    do_reset();
    en[0] = 1'b1; plen[0] = 4; npkt[0] = 1;
    en[3] = 1'b1; plen[3] = 4; npkt[3] = 1;
    refresh();
    for (int t = 0; t < 50 && lg_n < 1; t++) cycle();
    pause[0] = 1'b1;
    drive();
    repeat (5) begin
      #2;
      check("hold_ready", 64'(in_ready), 64'b0001);
      cycle();
    end
    pause[0] = 1'b0;
    drive();
    for (int t = 0; t < 100 && lg_n < 8; t++) cycle();
    check("hold_count", 64'(lg_n), 64'd8);
    for (int i = 0; i < 8; i++) check("hold_order", 64'(lg_sel[i]), 64'((i < 4) ? 0 : 3));

    // reset in the middle of an 8-beat packet from input 1
    do_reset();
    en[1] = 1'b1; plen[1] = 8; npkt[1] = 1;
    refresh();
    for (int t = 0; t < 50 && lg_n < 2; t++) cycle();
    areset = 1'b1;
    cycle();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd0);
    areset = 1'b0;
    src_clear();
    en[0] = 1'b1; plen[0] = 2; npkt[0] = 1;
    en[1] = 1'b1; plen[1] = 2; npkt[1] = 1;
    refresh();
    for (int t = 0; t < 50 && lg_n < 4; t++) cycle();
    check("midrst_first", 64'(lg_sel[0]), 64'd0);
    check("midrst_second", 64'(lg_sel[2]), 64'd1);

    // randomized traffic and back-pressure
    do_reset();
    rnd = 1'b1;
    for (int s = 0; s < NI; s++) begin
      en[s] = 1'b1; plen[s] = 0; npkt[s] = -1;
    end
    refresh();
    repeat (3000) begin
      out_ready = ($urandom_range(3) != 0);
      cycle();
    end
    out_ready = 1'b1;
    for (int s = 0; s < NI; s++) en[s] = 1'b0;
    for (int t = 0; t < 500 && !drained(); t++) cycle();
    check("rand_drained", 64'(drained()), 64'd1);
    tot = 0;
    for (int s = 0; s < NI; s++) begin
      check("rand_all_beats", 64'(out_cnt[s]), 64'(gen_cnt[s]));
      tot += gen_cnt[s];
    end
    check("rand_traffic", 64'(tot > 500), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_arbiter.md
# stream_arbiter

Round-robin packet arbiter that shares one AXI4-Stream-style output between `NUM_INPUTS` input streams. It grants one input at a time and holds the grant for a whole packet, until the beat with `in_last` set. Output data, last and select are registered in a single pipeline stage that accepts a new beat every cycle. It sits in front of a shared sink, such as a DMA writer or FIFO, fed by several acquisition channels.

## Interface
- `DATA_WIDTH`, 32: beat width in bits.
- `NUM_INPUTS`, 4: number of requesters, ≥ 2.
- `SEL_WIDTH`, `$clog2(NUM_INPUTS)`: width of the grant index.

Ports:
- `aclk`  in  1: clock; single clock domain.
- `areset`  in  1: reset, synchronous, active-high.
- `in_data`  in  `NUM_INPUTS*DATA_WIDTH`: input i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_valid`  in  `NUM_INPUTS`: per-input valid.
- `in_last`  in  `NUM_INPUTS`: per-input end-of-packet.
- `in_ready`  out  `NUM_INPUTS`: per-input ready; at most one bit set.
- `out_data`  out  `DATA_WIDTH`: registered beat.
- `out_last`  out  1: registered end-of-packet.
- `out_sel`  out  `SEL_WIDTH`: source index of the current output beat.
- `out_valid`  out  1: registered valid.
- `out_ready`  in  1: downstream ready.

## Operation
- Reset values:
  - `out_valid`, `out_last`, `out_data`, `out_sel`: 0.
  - `in_ready`: all 0.
  - state: IDLE.
  - `last_grant`: `NUM_INPUTS-1`, so input 0 has first priority.
- Output stage load enable: `load = ~out_valid | out_ready`.
- States:
  - IDLE: `in_ready` = 0.
    - If any `in_valid` is set, choose the first valid input searching from `last_grant+1` upward with wrap-around.
    - Register the result as `grant` and go to BUSY.
    - If no input is valid, stay in IDLE.
  - BUSY: `in_ready[grant] = load`; all other ready bits are 0.
    - A transfer happens when `in_valid[grant] & in_ready[grant]`.
    - On a transfer, the output stage captures `in_data[grant]` and `in_last[grant]`, sets `out_sel = grant` and sets `out_valid = 1`.
    - A transfer with `in_last` set returns the state to IDLE and sets `last_grant = grant`.
- Output stage with no new transfer: if `out_ready` is high, `out_valid` clears.
- No preemption: if the granted input drops `in_valid` mid-packet, the grant is held indefinitely.
- Arbitration considers only `in_valid`, never `in_last`.
- Single-beat packet (`in_valid` and `in_last` on the first beat): BUSY lasts exactly one transfer.
- Reset mid-packet: the partial packet is abandoned, the output stage is cleared, and state and `last_grant` take their reset values. The source must restart its packet.

## Timing
- Latency from input handshake to `out_valid`: 1 cycle.
- Arbitration overhead: 1 idle cycle (IDLE) per packet. Sustained throughput is L/(L+1) beats per cycle for L-beat packets when `out_ready` is held high.
- Arbitration costs at least 1 cycle from a request in IDLE to the first `in_ready`.
- While `out_valid & ~out_ready`, `out_data`, `out_last` and `out_sel` stay stable, and `in_ready` is 0.
- `in_ready` depends combinationally on `out_ready`. The timing path `out_ready -> in_ready` is accepted.
- A new grant decision in IDLE uses the `last_grant` value updated by the preceding last beat. No input is granted twice in a row while another input is requesting.

## Structure
- Package `stream_arbiter_pkg`: state encoding constants `ST_IDLE = 1'b0` and `ST_BUSY = 1'b1`.
- One sub-module, `rr_select`, parameterised on `NUM_INPUTS`:
  - purely combinational;
  - inputs: `req[NUM_INPUTS-1:0]`, `last[SEL_WIDTH-1:0]`;
  - outputs: `sel[SEL_WIDTH-1:0]`, `any`;
  - implements the rotate, priority-encode and un-rotate search.
- The top level holds the FSM, grant registers, input mux and output register.

## Test plan
- Reset, then all four inputs valid with 2-beat packets and `out_ready = 1`:
  - `out_sel` sequence is 0,0,1,1,2,2,3,3,0,…;
  - exactly one bubble cycle between packets.
- Only input 2 valid, 1-beat packets `0xA5A5A5A5`:
  - `out_data = 0xA5A5A5A5`, `out_sel = 2`, `out_last = 1`;
  - `out_valid` high every other cycle.
- Input 1 mid-packet (beat 2 of 4) with `out_ready` held low for 3 cycles:
  - output is held stable;
  - `in_ready[1] = 0`;
  - no beat is lost or duplicated;
  - the packet completes after `out_ready` returns.
- Input 0 drops `in_valid` for 5 cycles mid-packet while input 3 is requesting:
  - grant stays on 0;
  - input 3 is served only after input 0's `in_last`.
- Assert `areset` during beat 3 of an 8-beat packet from input 1:
  - next cycle `out_valid = 0` and `in_ready = 0`;
  - after release with inputs 0 and 1 valid, input 0 is granted first.
- Random stream with random `out_ready` and a scoreboard:
  - every input's beat order is preserved;
  - packets are never interleaved;
  - `in_ready` is never asserted for more than one input.
